// File: rtl/seq_logger_pkg.sv
// Shared constants and types for the sequence event logger.
package seq_logger_pkg;

  localparam int unsigned TS_WIDTH_DEF  = 16;
  localparam int unsigned DEPTH_DEF     = 4;
  localparam int unsigned CNT_WIDTH_DEF = 8;

  typedef logic [TS_WIDTH_DEF-1:0] ts_t;

endpackage

// File: rtl/seq_event_fifo.sv
// Show-ahead FIFO with a registered head entry, valid and full flags.
module seq_event_fifo
  import seq_logger_pkg::*;
#(
  parameter int unsigned WIDTH = TS_WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_full;
  logic [WIDTH-1:0] r_data;

  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_remain;
  logic [CW-1:0]    w_count_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  // A push while full is only accepted if the head leaves in the same cycle.
  always_comb begin
    w_pop       = i_pop & r_valid;
    w_push      = i_push & (~r_full | w_pop);
    w_remain    = r_count - CW'(w_pop);
    w_count_nxt = w_remain + CW'(w_push);
    w_rd_nxt    = r_rd + AW'(w_pop);
    w_head_nxt  = (w_remain == '0) ? i_data : r_mem[w_rd_nxt];
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_full  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= w_rd_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_count_nxt != '0) r_data <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_full  = r_full;

endmodule

// File: rtl/seq_event_logger.sv
// Timestamps rising edges of sequence_found into a FIFO; keeps a saturating
// detection count and a sticky drop flag.
module seq_event_logger
  import seq_logger_pkg::*;
#(
  parameter int unsigned TS_WIDTH  = TS_WIDTH_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sequence_found,
  input  logic                 clear,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [TS_WIDTH-1:0]  evt_timestamp,
  output logic [CNT_WIDTH-1:0] det_count,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 r_prev_found;
  logic [TS_WIDTH-1:0]  r_ts;
  logic [CNT_WIDTH-1:0] r_det_count;
  logic                 r_overflow;

  logic                 w_hit;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_drop;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_ovf_nxt;

  seq_event_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_hit),
    .i_data  (r_ts),
    .i_pop   (evt_ready),
    .o_valid (evt_valid),
    .o_data  (evt_timestamp),
    .o_full  (w_full)
  );

  // Counter and flag updates; clear takes priority but still counts a same-cycle hit.
  always_comb begin
    w_hit     = sequence_found & ~r_prev_found;
    w_pop     = evt_valid & evt_ready;
    w_drop    = w_hit & w_full & ~w_pop;
    w_cnt_nxt = r_det_count;
    w_ovf_nxt = r_overflow | w_drop;
    if (clear) begin
      w_cnt_nxt = CNT_WIDTH'(w_hit);
      w_ovf_nxt = w_drop;
    end else if (w_hit && (r_det_count != CNT_MAX)) begin
      w_cnt_nxt = r_det_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev_found <= 1'b0;
      r_ts         <= '0;
      r_det_count  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_prev_found <= sequence_found;
      r_ts         <= r_ts + TS_WIDTH'(1);
      r_det_count  <= w_cnt_nxt;
      r_overflow   <= w_ovf_nxt;
    end
  end

  assign det_count = r_det_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_event_logger.sv
// Randomized and directed bench for seq_event_logger with a queue-based reference model.
module tb_seq_event_logger;

  localparam int TSW   = 4;
  localparam int DEP   = 4;
  localparam int CNTW  = 4;
  localparam int TMASK = (1 << TSW) - 1;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clock;
  logic            reset;
  logic            sequence_found;
  logic            clear;
  logic            evt_ready;
  logic            evt_valid;
  logic [TSW-1:0]  evt_timestamp;
  logic [CNTW-1:0] det_count;
  logic            overflow;

  seq_event_logger #(
    .TS_WIDTH  (TSW),
    .DEPTH     (DEP),
    .CNT_WIDTH (CNTW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .sequence_found (sequence_found),
    .clear          (clear),
    .evt_ready      (evt_ready),
    .evt_valid      (evt_valid),
    .evt_timestamp  (evt_timestamp),
    .det_count      (det_count),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int m_ts   = 0;
  int m_prev = 0;
  int m_cnt  = 0;
  int m_ovf  = 0;
  int m_fifo[$];
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every accepted detection enters the model FIFO and the scoreboard queue.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_ts = 0; m_prev = 0; m_cnt = 0; m_ovf = 0;
        m_fifo.delete();
        exp_q.delete();
      end else begin
        int  hit;
        int  pop;
        int  full;
        int  drop;
        hit    = (sequence_found && m_prev == 0) ? 1 : 0;
        m_prev = sequence_found ? 1 : 0;
        pop    = (m_fifo.size() > 0 && evt_ready) ? 1 : 0;
        full   = (m_fifo.size() == DEP) ? 1 : 0;
        drop   = 0;
        if (pop != 0) void'(m_fifo.pop_front());
        if (hit != 0) begin
          if (full == 0 || pop != 0) begin
            m_fifo.push_back(m_ts);
            exp_q.push_back(m_ts);
          end else begin
            drop = 1;
          end
        end
        if (clear) begin
          m_cnt = hit;
          m_ovf = drop;
        end else begin
          if (hit != 0 && m_cnt < CMAX) m_cnt++;
          if (drop != 0) m_ovf = 1;
        end
        m_ts = (m_ts + 1) & TMASK;
      end
    end
  end

  // Monitor: compares flags every cycle and pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("evt_valid", int'(evt_valid), (m_fifo.size() > 0) ? 1 : 0);
        check("det_count", int'(det_count), m_cnt);
        check("overflow", int'(overflow), m_ovf);
        if (m_fifo.size() > 0) check("head_ts", int'(evt_timestamp), m_fifo[0]);
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_unexpected: got ts %0d expected no entry", evt_timestamp);
          end else begin
            check("pop_ts", int'(evt_timestamp), exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic sf, input logic rdy, input logic clr);
    sequence_found = sf;
    evt_ready      = rdy;
    clear          = clr;
    @(posedge clock);
    #2;
    cyc++;
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    sequence_found = 1'b0;
    evt_ready      = 1'b0;
    clear          = 1'b0;
    reset          = 1'b0;
    #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_ts", int'(evt_timestamp), 0);
    check("rst_det", int'(det_count), 0);
    check("rst_ovf", int'(overflow), 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int pulses[5];
    int rdy_pct;
    reset          = 1'b1;
    sequence_found = 1'b0;
    evt_ready      = 1'b0;
    clear          = 1'b0;
    #3;
    do_reset();

    // Single pulse at ts=5, consumer stalled
    idle_until(5);
    step(1'b1, 1'b0, 1'b0);
    check("pulse5_valid", int'(evt_valid), 1);
    check("pulse5_ts", int'(evt_timestamp), 5);
    check("pulse5_det", int'(det_count), 1);
    check("pulse5_ovf", int'(overflow), 0);
    drain(3);

    // Level held for cycles 10..13 gives one entry
    do_reset();
    idle_until(10);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("hold_det", int'(det_count), 1);
    check("hold_ts", int'(evt_timestamp), 10);
    drain(3);
    check("hold_empty", int'(evt_valid), 0);

    // Five pulses into a four-deep FIFO, then drain
    do_reset();
    pulses = '{2, 4, 6, 8, 10};
    foreach (pulses[i]) begin
      idle_until(pulses[i]);
      step(1'b1, 1'b0, 1'b0);
    end
    check("ovf_flag", int'(overflow), 1);
    check("ovf_det", int'(det_count), 5);
    check("ovf_head", int'(evt_timestamp), 2);
    drain(6);
    check("ovf_drained", int'(evt_valid), 0);

    // Full FIFO with a pulse coincident with a pop
    do_reset();
    for (int p = 1; p <= 7; p += 2) begin
      idle_until(p);
      step(1'b1, 1'b0, 1'b0);
    end
    idle_until(9);
    step(1'b1, 1'b1, 1'b0);
    check("fullpop_ovf", int'(overflow), 0);
    check("fullpop_det", int'(det_count), 5);
    check("fullpop_head", int'(evt_timestamp), 3);
    drain(6);

    // Clear without and with a coincident (dropped) hit
    do_reset();
    for (int p = 1; p <= 13; p += 2) begin
      idle_until(p);
      step(1'b1, 1'b0, 1'b0);
    end
    check("pre_clear_det", int'(det_count), 7);
    check("pre_clear_ovf", int'(overflow), 1);
    idle_until(15);
    step(1'b0, 1'b0, 1'b1);
    check("clear_det", int'(det_count), 0);
    check("clear_ovf", int'(overflow), 0);
    check("clear_keeps_fifo", int'(evt_valid), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("clear_hit_det", int'(det_count), 1);
    check("clear_hit_ovf", int'(overflow), 1);
    drain(6);

    // Timestamp wrap: pulses at ts=15 and at ts=0 of the next lap
    do_reset();
    idle_until(15);
    step(1'b1, 1'b0, 1'b0);
    idle_until(32);
    step(1'b1, 1'b0, 1'b0);
    check("wrap_head", int'(evt_timestamp), 15);
    step(1'b0, 1'b1, 1'b0);
    check("wrap_second", int'(evt_timestamp), 0);
    drain(3);

    // Reset with three entries queued
    do_reset();
    for (int p = 1; p <= 5; p += 2) begin
      idle_until(p);
      step(1'b1, 1'b0, 1'b0);
    end
    check("pre_rst_valid", int'(evt_valid), 1);
    do_reset();

    // Randomized traffic with varying consumer throttling
    rdy_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) rdy_pct = int'($urandom_range(0, 100));
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
             (int'($urandom_range(0, 99)) < rdy_pct) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      end
    end
    drain(8);
    check("final_empty", int'(evt_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
